// File: rtl/avalon_interval_timer_v2_pkg.sv
// Shared constants and types for the Avalon-MM interval timer: register map,
// CONTROL/STATUS bit positions and the command bundle from decode to the counter core.
package avalon_timer_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_PERIODL = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_PERIODH = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_SNAPL   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_SNAPH   = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;

   // One-cycle commands decoded from a bus write.
   typedef struct packed {
      logic start;
      logic stop;
      logic period_wr;
      logic status_wr;
   } core_cmd_t;

endpackage

// File: rtl/avalon_interval_timer_v2_if.sv
// Avalon-MM slave bus bundle for the interval timer (16-bit data, 3-bit word address).
interface avalon_interval_timer_v2_if;
   import avalon_timer_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/avalon_interval_timer_v2_core.sv
// Down-counter with RUN/TO state, periodic or one-shot reload, and a registered
// timeout strobe that rises in the same cycle TO becomes set.
module timer_core
   import avalon_timer_pkg::*;
#(
   parameter int                       COUNTER_WIDTH  = 32,
   parameter logic [COUNTER_WIDTH-1:0] RESET_COUNT    = '0,
   parameter bit                       START_AT_RESET = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  core_cmd_t                cmd,
   input  logic                     cont,
   input  logic [COUNTER_WIDTH-1:0] period,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     run,
   output logic                     to,
   output logic                     timeout_pulse
);

   localparam logic [COUNTER_WIDTH-1:0] ONE = 1;

   logic                     reload_pending;
   logic                     timeout_event;
   logic [COUNTER_WIDTH-1:0] count_d;
   logic                     run_d;
   logic                     to_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      count_d       = count;
      run_d         = run;
      to_d          = to;
      timeout_event = run && (count == '0);

      // A pending reload from a period write beats both decrement and timeout reload.
      if (reload_pending)     count_d = period;
      else if (timeout_event) count_d = period;
      else if (run)           count_d = count - ONE;

      // Later assignments take priority: STOP over period write over START over one-shot.
      if (timeout_event && !cont) run_d = 1'b0;
      if (cmd.start)              run_d = 1'b1;
      if (cmd.period_wr)          run_d = 1'b0;
      if (cmd.stop)               run_d = 1'b0;

      // The timeout event wins over a same-cycle STATUS write.
      if (cmd.status_wr) to_d = 1'b0;
      if (timeout_event) to_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count          <= RESET_COUNT;
         run            <= START_AT_RESET;
         to             <= 1'b0;
         timeout_pulse  <= 1'b0;
         reload_pending <= 1'b0;
      end else begin
         count          <= count_d;
         run            <= run_d;
         to             <= to_d;
         timeout_pulse  <= timeout_event;
         reload_pending <= cmd.period_wr;
      end
   end

endmodule

// File: rtl/avalon_interval_timer_v2.sv
// Avalon-MM interval timer: register decode, period/control/snapshot registers and
// registered read mux around timer_core. irq is the level TO & ITO.
module avalon_interval_timer_v2
   import avalon_timer_pkg::*;
#(
   parameter int          COUNTER_WIDTH  = 32,
   parameter logic [31:0] RESET_PERIOD   = 32'h0000C34F,
   parameter bit          START_AT_RESET = 1'b0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   avalon_interval_timer_v2_if.slave   bus,
   output logic                        irq,
   output logic                        timeout_pulse
);

   localparam int                       HI_W       = COUNTER_WIDTH - 16;
   localparam logic [COUNTER_WIDTH-1:0] RST_PERIOD = RESET_PERIOD[COUNTER_WIDTH-1:0];

   logic                     wr;
   core_cmd_t                cmd;
   logic                     ito;
   logic                     cont;
   logic [COUNTER_WIDTH-1:0] period;
   logic [COUNTER_WIDTH-1:0] snap;
   logic [COUNTER_WIDTH-1:0] count;
   logic                     run;
   logic                     to;
   logic [31:0]              period_ext;
   logic [31:0]              snap_ext;
   logic [DATA_W-1:0]        rd_mux;
   logic [DATA_W-1:0]        readdata_q;

   assign wr         = bus.chipselect & ~bus.write_n;
   assign period_ext = 32'(period);
   assign snap_ext   = 32'(snap);
   assign irq        = to & ito;
   assign bus.readdata = readdata_q;

   always_comb begin
      cmd = '0;
      if (wr) begin
         case (bus.address)
            ADDR_STATUS:  cmd.status_wr = 1'b1;
            ADDR_CONTROL: begin
               cmd.start = bus.writedata[CTRL_START];
               cmd.stop  = bus.writedata[CTRL_STOP];
            end
            ADDR_PERIODL,
            ADDR_PERIODH: cmd.period_wr = 1'b1;
            default:      ;
         endcase
      end
   end

   // The read mux ignores chipselect; the bus sees it one cycle after the address.
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_STATUS: begin
            rd_mux[ST_TO]  = to;
            rd_mux[ST_RUN] = run;
         end
         ADDR_CONTROL: begin
            rd_mux[CTRL_ITO]  = ito;
            rd_mux[CTRL_CONT] = cont;
         end
         ADDR_PERIODL: rd_mux = period_ext[15:0];
         ADDR_PERIODH: rd_mux = period_ext[31:16];
         ADDR_SNAPL:   rd_mux = snap_ext[15:0];
         ADDR_SNAPH:   rd_mux = snap_ext[31:16];
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ito        <= 1'b0;
         cont       <= START_AT_RESET;
         period     <= RST_PERIOD;
         snap       <= '0;
         readdata_q <= '0;
      end else begin
         readdata_q <= rd_mux;
         if (wr) begin
            case (bus.address)
               ADDR_CONTROL: begin
                  ito  <= bus.writedata[CTRL_ITO];
                  cont <= bus.writedata[CTRL_CONT];
               end
               ADDR_PERIODL: period[15:0]              <= bus.writedata;
               ADDR_PERIODH: period[COUNTER_WIDTH-1:16] <= bus.writedata[HI_W-1:0];
               // Snapshot takes the counter as it stands before this edge's decrement.
               ADDR_SNAPL,
               ADDR_SNAPH:   snap <= count;
               default:      ;
            endcase
         end
      end
   end

   timer_core #(
      .COUNTER_WIDTH  (COUNTER_WIDTH),
      .RESET_COUNT    (RST_PERIOD),
      .START_AT_RESET (START_AT_RESET)
   ) u_core (
      .clk           (clk),
      .reset_n       (reset_n),
      .cmd           (cmd),
      .cont          (cont),
      .period        (period),
      .count         (count),
      .run           (run),
      .to            (to),
      .timeout_pulse (timeout_pulse)
   );

endmodule

// File: tb/tb_avalon_interval_timer_v2.sv
// Scoreboard bench: the driver steps a behavioural timer model and queues the expected
// pulse/irq/readdata for each clock; a monitor pops and compares just after each edge.
module tb_avalon_interval_timer_v2;
   import avalon_timer_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic irq;
   logic timeout_pulse;

   avalon_interval_timer_v2_if bus();

   avalon_interval_timer_v2 #(
      .COUNTER_WIDTH  (32),
      .RESET_PERIOD   (32'h0000C34F),
      .START_AT_RESET (1'b0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .irq           (irq),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_read;
      logic [2:0]  addr;
      logic [15:0] rdata;
      bit          irq;
      bit          pulse;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: timer state expressed as plain integers.
   bit [31:0] m_period, m_count, m_snap;
   bit        m_run, m_cont, m_ito, m_to;
   longint    m_cyc;
   longint    m_reload_at;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      m_period    = 32'h0000C34F;
      m_count     = 32'h0000C34F;
      m_snap      = 0;
      m_run       = 0;
      m_cont      = 0;
      m_ito       = 0;
      m_to        = 0;
      m_reload_at = -1;
   endfunction

   function automatic logic [15:0] model_read(input logic [2:0] addr);
      case (addr)
         3'd0:    return {14'b0, m_run, m_to};
         3'd1:    return {14'b0, m_cont, m_ito};
         3'd2:    return m_period[15:0];
         3'd3:    return m_period[31:16];
         3'd4:    return m_snap[15:0];
         3'd5:    return m_snap[31:16];
         default: return 16'h0000;
      endcase
   endfunction

   // Drive one bus cycle at the falling edge, advance the model across the next
   // rising edge and queue what the DUT should show after that edge.
   task automatic cycle(input bit cs, input bit wr, input logic [2:0] addr,
                        input logic [15:0] wdata, input bit rd);
      exp_t      e;
      bit        ev;
      bit [31:0] cnt_n;
      bit        run_n, to_n, ito_n, cont_n;
      bus.chipselect = cs;
      bus.write_n    = ~wr;
      bus.address    = addr;
      bus.writedata  = wdata;

      e.is_read = rd;
      e.addr    = addr;
      e.rdata   = model_read(addr);

      ev = m_run && (m_count == 0);
      if (m_reload_at == m_cyc) cnt_n = m_period;
      else if (ev)              cnt_n = m_period;
      else if (m_run)           cnt_n = m_count - 1;
      else                      cnt_n = m_count;

      run_n  = m_run;
      ito_n  = m_ito;
      cont_n = m_cont;
      to_n   = m_to;
      if (ev && !m_cont) run_n = 0;
      if (wr) begin
         case (addr)
            3'd0: to_n = 0;
            3'd1: begin
               ito_n  = wdata[0];
               cont_n = wdata[1];
               if (wdata[2]) run_n = 1;
               if (wdata[3]) run_n = 0;
            end
            3'd2: begin m_period[15:0]  = wdata; run_n = 0; m_reload_at = m_cyc + 1; end
            3'd3: begin m_period[31:16] = wdata; run_n = 0; m_reload_at = m_cyc + 1; end
            3'd4, 3'd5: m_snap = m_count;
            default: ;
         endcase
      end
      if (ev) to_n = 1;

      m_count = cnt_n;
      m_run   = run_n;
      m_to    = to_n;
      m_ito   = ito_n;
      m_cont  = cont_n;

      e.pulse = ev;
      e.irq   = m_to & m_ito;
      exp_q.push_back(e);
      m_cyc++;
      @(negedge clk);
   endtask

   task automatic wr_reg(input logic [2:0] addr, input logic [15:0] data);
      cycle(1'b1, 1'b1, addr, data, 1'b0);
   endtask

   task automatic rd_reg(input logic [2:0] addr);
      cycle(1'b1, 1'b0, addr, 16'h0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
   endtask

   task automatic bound_expired(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Monitor: one queued expectation per clock edge while the bench is driving.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("timeout_pulse", timeout_pulse, e.pulse);
            check("irq", irq, e.irq);
            if (e.is_read) check($sformatf("readdata[addr %0d]", e.addr), bus.readdata, e.rdata);
         end
      end
   end

   initial begin : watchdog
      #(10 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int guard;
      bus.chipselect = 0;
      bus.write_n    = 1;
      bus.address    = 0;
      bus.writedata  = 0;
      model_reset();
      m_cyc = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset readdata", bus.readdata, 16'h0000);
      check("reset irq", irq, 1'b0);
      check("reset timeout_pulse", timeout_pulse, 1'b0);
      reset_n = 1'b1;
      rd_reg(ADDR_STATUS);
      rd_reg(ADDR_CONTROL);
      rd_reg(ADDR_PERIODL);
      rd_reg(ADDR_PERIODH);
      wr_reg(ADDR_SNAPL, 16'h0);
      rd_reg(ADDR_SNAPL);
      rd_reg(ADDR_SNAPH);
      idle(5000);
      wr_reg(ADDR_SNAPH, 16'h0);
      rd_reg(ADDR_SNAPL);

      // Continuous period 9 with interrupt enabled; clear TO with a STATUS write
      wr_reg(ADDR_PERIODL, 16'd9);
      wr_reg(ADDR_PERIODH, 16'd0);
      wr_reg(ADDR_CONTROL, 16'h0007);
      idle(35);
      rd_reg(ADDR_STATUS);
      rd_reg(ADDR_CONTROL);
      wr_reg(ADDR_STATUS, 16'h0);
      rd_reg(ADDR_STATUS);
      idle(12);

      // One-shot period 4
      wr_reg(ADDR_PERIODL, 16'd4);
      wr_reg(ADDR_CONTROL, 16'h0005);
      idle(20);
      rd_reg(ADDR_STATUS);

      // Period above 16 bits with a snapshot after three counting clocks
      wr_reg(ADDR_PERIODH, 16'h0001);
      wr_reg(ADDR_PERIODL, 16'h0000);
      wr_reg(ADDR_CONTROL, 16'h0004);
      idle(3);
      wr_reg(ADDR_SNAPL, 16'h0);
      rd_reg(ADDR_SNAPL);
      rd_reg(ADDR_SNAPH);
      rd_reg(ADDR_PERIODH);

      // STATUS write landing on the same edge as a timeout event
      wr_reg(ADDR_PERIODH, 16'h0000);
      wr_reg(ADDR_PERIODL, 16'd3);
      wr_reg(ADDR_CONTROL, 16'h0007);
      guard = 0;
      while (!m_to && guard < 50) begin idle(1); guard++; end
      if (guard >= 50) bound_expired("wait first event");
      guard = 0;
      while (!(m_run && m_count == 0) && guard < 50) begin idle(1); guard++; end
      if (guard >= 50) bound_expired("wait event edge");
      wr_reg(ADDR_STATUS, 16'hFFFF);
      rd_reg(ADDR_STATUS);

      // START|STOP together while running, then a reload with RUN held low
      wr_reg(ADDR_PERIODL, 16'd40);
      wr_reg(ADDR_CONTROL, 16'h0006);
      idle(7);
      wr_reg(ADDR_CONTROL, 16'h000C);
      idle(5);
      wr_reg(ADDR_SNAPL, 16'h0);
      rd_reg(ADDR_SNAPL);
      rd_reg(ADDR_STATUS);
      wr_reg(ADDR_PERIODL, 16'd7);
      idle(3);
      wr_reg(ADDR_SNAPH, 16'h0);
      rd_reg(ADDR_SNAPL);
      rd_reg(ADDR_STATUS);
      rd_reg(3'd6);

      // Asynchronous reset while counting with irq asserted
      wr_reg(ADDR_PERIODL, 16'd4);
      wr_reg(ADDR_CONTROL, 16'h0007);
      idle(12);
      rd_reg(ADDR_PERIODL);
      bus.chipselect = 0;
      bus.write_n    = 1;
      #2 reset_n = 1'b0;
      #1;
      check("async reset readdata", bus.readdata, 16'h0000);
      check("async reset irq", irq, 1'b0);
      check("async reset timeout_pulse", timeout_pulse, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      check("in reset timeout_pulse", timeout_pulse, 1'b0);
      reset_n = 1'b1;
      wr_reg(ADDR_SNAPL, 16'h0);
      rd_reg(ADDR_SNAPL);
      rd_reg(ADDR_STATUS);

      // Randomised register traffic against the model
      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 9))
            0:       wr_reg(ADDR_PERIODL, 16'($urandom_range(0, 12)));
            1:       wr_reg(ADDR_PERIODH, ($urandom_range(0, 7) == 0) ? 16'h0001 : 16'h0000);
            2:       wr_reg(ADDR_CONTROL, 16'($urandom_range(0, 15)));
            3:       wr_reg(ADDR_STATUS, 16'($urandom));
            4:       wr_reg(3'($urandom_range(4, 5)), 16'($urandom));
            5:       wr_reg(3'($urandom_range(6, 7)), 16'($urandom));
            6, 7:    rd_reg(3'($urandom_range(0, 7)));
            default: idle($urandom_range(1, 8));
         endcase
      end

      idle(2);
      check("scoreboard drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
